// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the instruction fetch front end.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One prefetch buffer entry: the instruction word tagged with its address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head entry is visible on dout whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: issues sequential fetches, buffers tagged responses and
// hands them to the CPU in order; redirects flush the buffer and drop stale responses.
module instr_prefetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc
);

    localparam int AW    = $clog2(DEPTH);
    // Wide enough that discarded responses from back-to-back redirects never wrap.
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  fetch_pc_reg;
    logic [XLEN-1:0]  fetch_pc_next;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard_cnt_reg;
    logic [CNT_W-1:0] discard_cnt_next;
    logic             started_reg;

    logic [CNT_W-1:0] pending_total;
    logic [CNT_W-1:0] in_flight;
    logic             req_fire;
    logic             rsp_keep;
    logic             rsp_drop;
    logic             buf_pop;
    logic             buf_empty;
    logic [AW:0]      buf_count;
    fetch_entry_t     buf_wr;
    fetch_entry_t     buf_rd;
    logic [XLEN-1:0]  tag_pc;
    logic             tag_empty_unused;
    logic [AW:0]      tag_count_unused;
    logic [1:0]       redirect_pc_lsb_unused;

    assign redirect_pc_lsb_unused = redirect_pc[1:0];

    // Buffered entries plus kept in-flight requests bound how many more may be issued.
    assign in_flight      = CNT_W'(buf_count) + outstanding_reg;
    assign pending_total  = outstanding_reg + discard_cnt_reg;
    assign imem_req_valid = started_reg && !redirect && (in_flight < CNT_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (discard_cnt_reg != '0);
    assign rsp_keep = imem_rsp_valid && !redirect && (discard_cnt_reg == '0)
                      && (outstanding_reg != '0);

    assign instr_valid = !buf_empty;
    assign buf_pop     = instr_valid && instr_ready;
    assign instr_out   = instr_valid ? buf_rd.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? buf_rd.pc : fetch_pc_reg;

    assign buf_wr.pc    = tag_pc;
    assign buf_wr.instr = imem_rsp_data;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        outstanding_next = outstanding_reg;
        discard_cnt_next = discard_cnt_reg;
        if (redirect) begin
            // Every pending response becomes stale, except one consumed this very cycle.
            fetch_pc_next    = {redirect_pc[XLEN-1:2], 2'b00};
            outstanding_next = '0;
            if (imem_rsp_valid && (pending_total != '0)) begin
                discard_cnt_next = pending_total - CNT_ONE;
            end else begin
                discard_cnt_next = pending_total;
            end
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (rsp_drop) begin
                discard_cnt_next = discard_cnt_reg - CNT_ONE;
            end
            if (req_fire && !rsp_keep) begin
                outstanding_next = outstanding_reg + CNT_ONE;
            end else if (!req_fire && rsp_keep) begin
                outstanding_next = outstanding_reg - CNT_ONE;
            end
        end
    end

    // started_reg keeps the request port quiet until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            discard_cnt_reg <= '0;
            started_reg     <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            discard_cnt_reg <= discard_cnt_next;
            started_reg     <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (req_fire),
        .din   (fetch_pc_reg),
        .pop   (rsp_keep),
        .dout  (tag_pc),
        .empty (tag_empty_unused),
        .count (tag_count_unused)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (rsp_keep),
        .din   (buf_wr),
        .pop   (buf_pop),
        .dout  (buf_rd),
        .empty (buf_empty),
        .count (buf_count)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench for instr_prefetch: an in-order memory model plus an architectural
// fetch-stream model (consecutive PCs from reset/redirect target, data = mem_word(pc)).
module tb_instr_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    instr_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          issued_since = 0;
    int          popped_since = 0;
    int          req_count = 0;
    int          pop_count = 0;
    bit          after_redirect = 0;
    bit          stall_prev = 0;
    logic [31:0] stall_addr;
    int          lat_min = 1, lat_max = 1;
    int          ready_pct = 100, iready_pct = 100, redir_pct = 0;
    int          redir_mode = 0;
    logic [31:0] redir_target;
    bit          redir_hit = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_checks();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out", instr_out, NOP);
        check("rst_instr_pc", instr_pc, RESET_PC);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_pc = RESET_PC;
        exp_req = RESET_PC;
        issued_since = 0;
        popped_since = 0;
        after_redirect = 0;
        stall_prev = 0;
    endtask

    // One clock cycle: drive inputs after the edge, observe and update the model at negedge.
    task automatic step();
        bit rd;
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        instr_ready    = ($urandom_range(99) < iready_pct);
        redirect       = 1'b0;
        redirect_pc    = $urandom;
        #1;
        rd = (redir_mode == 1) ||
             (redir_mode == 2 && instr_valid && instr_ready && imem_rsp_valid);
        if (rd) begin
            redirect    = 1'b1;
            redirect_pc = redir_target;
            redir_hit   = 1'b1;
            redir_mode  = 0;
        end else if (redir_mode == 0 && $urandom_range(99) < redir_pct) begin
            redirect = 1'b1;
        end
        @(negedge clk);
        if (after_redirect) check("valid_after_redirect", 32'(instr_valid), 32'd0);
        after_redirect = redirect;
        if (redirect) check("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
        if (stall_prev && !redirect) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, stall_addr);
        end
        stall_prev = imem_req_valid && !imem_req_ready;
        stall_addr = imem_req_addr;
        if (instr_valid && instr_ready) begin
            $display("cyc %0d pop pc=%h instr=%h", cyc, instr_pc, instr_out);
            check("instr_pc", instr_pc, exp_pc);
            check("instr_out", instr_out, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            popped_since++;
            pop_count++;
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req);
            mq.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
            exp_req = exp_req + 32'd4;
            issued_since++;
            req_count++;
        end
        check("inflight_bound", 32'(issued_since - popped_since <= DEPTH), 32'd1);
        if (redirect) begin
            exp_pc       = redirect_pc & ~32'h3;
            exp_req      = redirect_pc & ~32'h3;
            issued_since = 0;
            popped_since = 0;
        end
    endtask

    task automatic do_reset_async();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        reset_checks();
        imem_rsp_valid = 1'b0;
        redirect = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("req_valid_before_edge", 32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        instr_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("req_valid_before_edge", 32'(imem_req_valid), 32'd0);

        // Steady stream: always-ready memory, latency 1, CPU always ready.
        for (int i = 0; i < 10; i++) step();
        base = pop_count;
        for (int i = 0; i < 20; i++) step();
        check("steady_throughput", 32'(pop_count - base), 32'd20);

        // Asynchronous reset in the middle of the stream.
        do_reset_async();

        // CPU stalled: only DEPTH requests may go out.
        iready_pct = 0;
        base = req_count;
        for (int i = 0; i < 10; i++) step();
        check("stall_req_count", 32'(req_count - base), 32'(DEPTH));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        iready_pct = 100;
        for (int i = 0; i < 20; i++) step();

        // Redirect to 0x100 with three responses outstanding.
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 50 && mq.size() < 3; i++) step();
        check("three_outstanding", 32'(mq.size() >= 3), 32'd1);
        redir_target = 32'h0000_0100;
        redir_mode = 1;
        step();
        for (int i = 0; i < 20; i++) step();
        check("pops_after_redirect", 32'(popped_since > 0), 32'd1);

        // Redirect coinciding with a pop and a response arrival.
        lat_min = 1; lat_max = 3; ready_pct = 80; iready_pct = 70;
        redir_target = 32'h0000_2000;
        redir_hit = 0;
        redir_mode = 2;
        for (int i = 0; i < 200 && !redir_hit; i++) step();
        redir_mode = 0;
        check("coincide_hit", 32'(redir_hit), 32'd1);
        for (int i = 0; i < 20; i++) step();

        // Wrap at the top of the address space, then a misaligned target.
        lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100;
        redir_target = 32'hFFFF_FFFC;
        redir_mode = 1;
        step();
        for (int i = 0; i < 10; i++) step();
        redir_target = 32'h0000_0203;
        redir_mode = 1;
        step();
        for (int i = 0; i < 10; i++) step();

        // Fully random traffic with occasional redirects.
        lat_min = 1; lat_max = 4; ready_pct = 70; iready_pct = 60; redir_pct = 5;
        for (int i = 0; i < 400; i++) step();

        // Drain: no new requests, everything kept must reach the CPU.
        redir_pct = 0; ready_pct = 0; iready_pct = 100;
        for (int i = 0; i < 200 && (mq.size() > 0 || instr_valid); i++) step();
        check("drain_all_delivered", 32'(popped_since), 32'(issued_since));
        check("drain_empty", 32'(instr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of buffer entries; legal values are powers of two from 2 to 16.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port redirect, input, 1 bit: taken jump/branch; restart fetch at redirect_pc.
REQ-006 Port redirect_pc, input, 32 bits: new fetch address, sampled when redirect=1.
REQ-007 Port imem_req_valid, output, 1 bit: fetch request valid.
REQ-008 Port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-009 Port imem_req_addr, output, 32 bits: word-aligned fetch address.
REQ-010 Port imem_rsp_valid, input, 1 bit: response data valid; responses return in request order.
REQ-011 Port imem_rsp_data, input, 32 bits: fetched instruction word.
REQ-012 Port instr_valid, output, 1 bit: instr_out and instr_pc hold a valid instruction for the CPU.
REQ-013 Port instr_ready, input, 1 bit: the CPU consumes the instruction this cycle.
REQ-014 Port instr_out, output, 32 bits: instruction word driven to the CPU Instr input.
REQ-015 Port instr_pc, output, 32 bits: address of instr_out.

Function
REQ-016 A request SHALL be accepted in a cycle where imem_req_valid=1 and imem_req_ready=1; fetch_pc then advances by 4, wrapping modulo 2^32.
REQ-017 imem_req_valid SHALL be 1 only when occupancy + outstanding < DEPTH and redirect=0, so that every accepted response has a guaranteed free buffer slot.
REQ-018 imem_req_addr SHALL equal fetch_pc and SHALL remain stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 The outstanding count SHALL increment on request acceptance, decrement on each non-discarded response, and be unchanged when both occur in the same cycle.
REQ-020 A non-discarded response SHALL be written to the buffer together with its PC, taken from a per-request PC tag queue of depth DEPTH.
REQ-021 Latency: a response in cycle N SHALL appear on instr_out with instr_valid=1 no earlier than cycle N+1; there is no combinational path from rsp to instr.
REQ-022 An instruction SHALL be popped when instr_valid=1 and instr_ready=1; the buffer pointers SHALL wrap modulo DEPTH.
REQ-023 A push and a pop in the same cycle SHALL both take effect and leave occupancy unchanged.
REQ-024 On redirect=1: fetch_pc <= redirect_pc, the buffer and PC tag queue SHALL be flushed, instr_valid SHALL be 0 in the next cycle, and discard_cnt <= outstanding (less any response arriving in that same cycle).
REQ-025 While discard_cnt > 0, each arriving response SHALL be dropped and decrement discard_cnt; new requests are allowed during this time.
REQ-026 Redirect coinciding with a pop: the pop SHALL complete and then the flush SHALL apply; redirect has priority over any push in the same cycle.
REQ-027 A second redirect while discard_cnt > 0 SHALL set discard_cnt to the total of all still-pending responses.
REQ-028 A misaligned redirect_pc SHALL be forced aligned by clearing bits [1:0].

Reset
REQ-029 While reset=1, the module SHALL hold fetch_pc=RESET_PC, occupancy=0, outstanding=0, discard_cnt=0, imem_req_valid=0, instr_valid=0, instr_out=32'h0000_0013 (NOP) and instr_pc=RESET_PC.
REQ-030 imem_req_valid SHALL NOT assert before the first rising clk edge after reset deasserts.
REQ-031 Reset asserted mid-transfer SHALL abandon all in-flight state; responses to pre-reset requests that arrive after reset deassertion are the memory's responsibility and SHALL NOT be counted.

Structure
REQ-032 Package riscv_pkg SHALL hold XLEN=32, the NOP encoding 32'h0000_0013, and the RESET_PC default.
REQ-033 One sub-module, sync_fifo (parameters WIDTH and DEPTH, with a flush input), SHALL implement both the 64-bit {pc, instr} buffer and the PC tag queue.

Verification
REQ-034 Scenario: reset, memory always ready with 1-cycle latency, instr_ready=1 -> addresses 0x0, 0x4, 0x8, ... are fetched and instr_pc follows in order with one instruction per cycle in steady state.
REQ-035 Scenario: instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests are issued, imem_req_valid stays 0, and no data is lost once instr_ready returns to 1.
REQ-036 Scenario: redirect to 0x100 with 3 responses outstanding -> those 3 responses are dropped and the first instr_pc delivered is 0x100.
REQ-037 Scenario: redirect in the same cycle as a pop and a response arrival -> the popped instruction is delivered once, the response is discarded, and discard_cnt ends correct.
REQ-038 Scenario: redirect_pc=0xFFFF_FFFC -> the next fetches are 0xFFFF_FFFC then 0x0000_0000.
REQ-039 Scenario: reset asserted asynchronously mid-stream -> outputs take their reset values immediately and fetch restarts at RESET_PC.
